// File: rtl/pc_redirect_ctrl_if.sv
// Fetch-PC control bundle between the pipeline (master) and pc_redirect_ctrl (slave).
interface pc_redirect_ctrl_if;
    logic        stall_if;
    logic        stall_id;
    logic        br_valid;
    logic        take_branch;
    logic [31:0] PC_branch;
    logic        halt;
    logic [31:0] pc_out;
    logic [31:0] PC_4;
    logic        pc_en;
    logic        flush_ifid;
    logic        flush_idex;
    logic        halted;

    modport master (
        output stall_if, stall_id, br_valid, take_branch, PC_branch, halt,
        input  pc_out, PC_4, pc_en, flush_ifid, flush_idex, halted
    );

    modport slave (
        input  stall_if, stall_id, br_valid, take_branch, PC_branch, halt,
        output pc_out, PC_4, pc_en, flush_ifid, flush_idex, halted
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: sequential +4, branch redirect with IF/ID-ID/EX flush, stall hold, halt.
// Optional macro BR_PERF_CNT_EN adds saturating branch / taken-branch counters.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
`ifdef BR_PERF_CNT_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_redirect_ctrl_if.slave    bus
`ifdef BR_PERF_CNT_EN
    , output logic [CNT_W-1:0]   br_cnt
    , output logic [CNT_W-1:0]   taken_cnt
`endif
);

    localparam int unsigned PC_W = 32;
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] PEND   = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [PC_W-1:0] tgt, tgt_nxt;
    logic            halted_q;
    logic            pc_en_c, flush_ifid_c, flush_idex_c;

    logic            redirect;
    logic [PC_W-1:0] target;

    assign redirect = bus.br_valid & bus.take_branch;
    assign target   = bus.PC_branch & ~PC_W'(3);

    // Next-state, next-PC and combinational flush/enable strobes
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        tgt_nxt      = tgt;
        pc_en_c      = 1'b0;
        flush_ifid_c = 1'b0;
        flush_idex_c = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    flush_ifid_c = 1'b1;
                    flush_idex_c = 1'b1;
                    if (!bus.stall_if) begin
                        pc_nxt  = target;
                        pc_en_c = 1'b1;
                    end else begin
                        tgt_nxt   = target;
                        state_nxt = PEND;
                    end
                end else if (bus.halt && !bus.stall_id) begin
                    state_nxt = HALTED;
                end else if (!(bus.stall_if || bus.stall_id)) begin
                    pc_nxt  = pc + PC_W'(4);
                    pc_en_c = 1'b1;
                end
            end
            PEND: begin
                // Keep dropping the stale fetch until imem comes back
                flush_ifid_c = 1'b1;
                if (!bus.stall_if) begin
                    pc_nxt    = tgt;
                    pc_en_c   = 1'b1;
                    state_nxt = RUN;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        if (rst) begin
            pc_en_c      = 1'b0;
            flush_ifid_c = 1'b0;
            flush_idex_c = 1'b0;
        end
    end

    // State, PC, parked target and halted flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_VEC;
            tgt      <= '0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            tgt      <= tgt_nxt;
            halted_q <= (state_nxt == HALTED);
        end
    end

    assign bus.pc_out     = pc;
    assign bus.PC_4       = pc + PC_W'(4);
    assign bus.pc_en      = pc_en_c;
    assign bus.flush_ifid = flush_ifid_c;
    assign bus.flush_idex = flush_idex_c;
    assign bus.halted     = halted_q;

`ifdef BR_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating perf counters, only live while running
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (state == RUN) begin
            if (bus.br_valid && (br_cnt != CNT_MAX))
                br_cnt <= br_cnt + CNT_W'(1);
            if (redirect && (taken_cnt != CNT_MAX))
                taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: driver queues per-cycle expectations, monitor checks at negedge.
module tb_pc_redirect_ctrl;

    localparam logic [31:0] RVEC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_redirect_ctrl_if bus ();

`ifdef BR_PERF_CNT_EN
    logic [3:0] br_cnt, taken_cnt;
    pc_redirect_ctrl #(.RESET_VEC(RVEC), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .br_cnt(br_cnt), .taken_cnt(taken_cnt));
`else
    pc_redirect_ctrl #(.RESET_VEC(RVEC)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        fi;
        logic        fx;
        logic        en;
        logic        hl;
        logic        cc;
        logic [3:0]  brc;
        logic [3:0]  tkc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic       exp_cc = 1'b0;
    logic [3:0] exp_brc = '0;
    logic [3:0] exp_tkc = '0;

    function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endfunction

    // Monitor: every cycle the DUT presents a state, match it against the oldest expectation
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "pc_out",     bus.pc_out,     e.pc);
            chk(e.name, "PC_4",       bus.PC_4,       e.pc + 32'd4);
            chk(e.name, "flush_ifid", 32'(bus.flush_ifid), 32'(e.fi));
            chk(e.name, "flush_idex", 32'(bus.flush_idex), 32'(e.fx));
            chk(e.name, "pc_en",      32'(bus.pc_en),      32'(e.en));
            chk(e.name, "halted",     32'(bus.halted),     32'(e.hl));
`ifdef BR_PERF_CNT_EN
            if (e.cc) begin
                chk(e.name, "br_cnt",    32'(br_cnt),    32'(e.brc));
                chk(e.name, "taken_cnt", 32'(taken_cnt), 32'(e.tkc));
            end
`endif
        end
    end

    task automatic step(input string nm, input logic r, input logic sif, input logic sid,
                        input logic bv, input logic tk, input logic [31:0] tgt, input logic hlt,
                        input logic [31:0] epc, input logic efi, input logic efx,
                        input logic een, input logic ehl);
        exp_t e;
        rst             = r;
        bus.stall_if    = sif;
        bus.stall_id    = sid;
        bus.br_valid    = bv;
        bus.take_branch = tk;
        bus.PC_branch   = tgt;
        bus.halt        = hlt;
        e.name = nm; e.pc = epc; e.fi = efi; e.fx = efx; e.en = een; e.hl = ehl;
        e.cc = exp_cc; e.brc = exp_brc; e.tkc = exp_tkc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input logic [31:0] epc);
        step(nm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, epc, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.stall_if = 1'b0; bus.stall_id = 1'b0; bus.br_valid = 1'b0;
        bus.take_branch = 1'b0; bus.PC_branch = 32'h0; bus.halt = 1'b0;
        @(posedge clk);
        #1;

        // Reset: strobes forced low even with a redirect on the inputs
        exp_cc = 1'b1; exp_brc = 4'h0; exp_tkc = 4'h0;
        step("rst0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0abc, 1'b0, RVEC, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rst1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0abc, 1'b1, RVEC, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cc = 1'b0;

        // Sequential fetch
        idle("seq100", 32'h100);
        idle("seq104", 32'h104);
        idle("seq108", 32'h108);
        idle("seq10c", 32'h10c);

        // Taken redirect, low target bits dropped
        step("br203", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h203, 1'b0, 32'h110, 1'b1, 1'b1, 1'b1, 1'b0);
        idle("tgt200", 32'h200);
        idle("tgt204", 32'h204);

        // Redirect under imem stall parks in PEND, junk on inputs ignored
        step("pcap", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h208, 1'b1, 1'b1, 1'b0, 1'b0);
        step("pend0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0);
        step("pend1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0);
        step("pend2", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0);
        step("prel",  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h700, 1'b1, 32'h208, 1'b1, 1'b0, 1'b1, 1'b0);
        idle("tgt300", 32'h300);
        idle("tgt304", 32'h304);

        // Not-taken branch under ID stall holds; redirect beats ID stall
        step("nt_sid0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h900, 1'b0, 32'h308, 1'b0, 1'b0, 1'b0, 1'b0);
        step("nt_sid1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h900, 1'b0, 32'h308, 1'b0, 1'b0, 1'b0, 1'b0);
        idle("sid_rel", 32'h308);
        step("br_sid", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 32'h30c, 1'b1, 1'b1, 1'b1, 1'b0);
        idle("tgt400", 32'h400);

        // Redirect beats halt, then halt freezes until reset
        step("br_halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 32'h404, 1'b1, 1'b1, 1'b1, 1'b0);
        step("halt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            step($sformatf("halted%0d", i), 1'b0, 1'(i % 2), 1'(i % 3 == 0), 1'b1, 1'b1,
                 32'h800, 1'(i % 2), 32'h500, 1'b0, 1'b0, 1'b0, 1'b1);
        step("halt_rst", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h800, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1);
        idle("post_rst", RVEC);

        // Halt blocked by ID stall
        step("halt_sid", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0);
        idle("no_halt", 32'h104);

        // PC wrap at the top of the address space
        step("br_top", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hffff_ffff, 1'b0, 32'h108, 1'b1, 1'b1, 1'b1, 1'b0);
        idle("top", 32'hffff_fffc);
        idle("wrap0", 32'h0);
        for (int i = 0; i < 20; i++)
            step($sformatf("tk%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h600, 1'b0,
                 (i == 0) ? 32'h4 : 32'h600, 1'b1, 1'b1, 1'b1, 1'b0);
        exp_cc = 1'b1; exp_brc = 4'hf; exp_tkc = 4'hf;
        idle("cnt_sat", 32'h600);
        exp_cc = 1'b0;

        for (int i = 0; i < 4 && q.size() != 0; i++)
            @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
